// File: rtl/except_ctrl.sv
// except_ctrl: memory-stage exception controller feeding CP0.
// Selects one exception per instruction using forwarded CP0 state, issues a
// one-cycle code/flush/redirect pulse, then blanks detection while the
// pipeline refills.
module except_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00000020,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        exc_syscall_i,
  input  logic        exc_invalid_i,
  input  logic        exc_trap_i,
  input  logic        exc_ovf_i,
  input  logic        exc_eret_i,
  input  logic        stall_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] except_type_o,
  output logic [31:0] cur_inst_addr_o,
  output logic        in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        exc_busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int unsigned CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [31:0] CODE_INT     = 32'h1;
  localparam logic [31:0] CODE_INVALID = 32'ha;
  localparam logic [31:0] CODE_SYSCALL = 32'h8;
  localparam logic [31:0] CODE_TRAP    = 32'hd;
  localparam logic [31:0] CODE_OVF     = 32'hc;
  localparam logic [31:0] CODE_ERET    = 32'he;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   eff_status;
  logic [31:0]   eff_cause;
  logic [31:0]   eff_epc;
  logic          int_req;
  logic          detect;
  logic [31:0]   code;
  logic          unused_bits;

  // Forward any in-flight write-back CP0 write over the live register values.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == REG_STATUS) eff_status = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == REG_EPC)    eff_epc    = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == REG_CAUSE) begin
        eff_cause[9:8]   = wb_cp0_wdata_i[9:8];
        eff_cause[23:22] = wb_cp0_wdata_i[23:22];
      end
    end
  end

  assign int_req = eff_status[0] & ~eff_status[1] &
                   (|(eff_cause[15:8] & eff_status[15:8]));

  // Only the IE/EXL/IM/IP fields matter for detection.
  assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0]};

  assign detect = (state == IDLE) & inst_valid_i & ~stall_i;

  // Fixed-priority exception code selection.
  always_comb begin
    code = '0;
    if (detect) begin
      if (int_req)             code = CODE_INT;
      else if (exc_invalid_i)  code = CODE_INVALID;
      else if (exc_syscall_i)  code = CODE_SYSCALL;
      else if (exc_trap_i)     code = CODE_TRAP;
      else if (exc_ovf_i)      code = CODE_OVF;
      else if (exc_eret_i)     code = CODE_ERET;
    end
  end

  assign exc_busy_o = (state != IDLE);

  // State machine and registered outputs toward CP0 and the fetch stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      except_type_o   <= '0;
      cur_inst_addr_o <= '0;
      in_delayslot_o  <= 1'b0;
      flush_o         <= 1'b0;
      new_pc_o        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (code != '0) begin
            except_type_o   <= code;
            cur_inst_addr_o <= inst_addr_i;
            in_delayslot_o  <= in_delayslot_i;
            flush_o         <= 1'b1;
            new_pc_o        <= (code == CODE_ERET) ? eff_epc : HANDLER_ADDR;
            state           <= FLUSH;
          end
        end
        FLUSH: begin
          except_type_o <= '0;
          flush_o       <= 1'b0;
          new_pc_o      <= '0;
          cnt           <= CNT_INIT;
          state         <= (BLANK_CYCLES == 0) ? IDLE : HOLD;
        end
        HOLD: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a cycle-indexed behavioural model of except_ctrl.
module tb_except_ctrl;

  localparam int BLANK = 2;
  localparam logic [31:0] HANDLER = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, in_delayslot_i, stall_i;
  logic [31:0] inst_addr_i;
  logic        exc_syscall_i, exc_invalid_i, exc_trap_i, exc_ovf_i, exc_eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] except_type_o, cur_inst_addr_o, new_pc_o;
  logic        in_delayslot_o, flush_o, exc_busy_o;

  int total = 0;
  int bad = 0;

  // model state: cycle index, first cycle detection is allowed, expected outputs
  int          cyc = 0;
  int          idle_from = 0;
  logic [31:0] m_type, m_cur, m_pc;
  logic        m_ds, m_flush, m_busy;

  except_ctrl #(.HANDLER_ADDR(HANDLER), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .in_delayslot_i(in_delayslot_i),
    .exc_syscall_i(exc_syscall_i), .exc_invalid_i(exc_invalid_i),
    .exc_trap_i(exc_trap_i), .exc_ovf_i(exc_ovf_i), .exc_eret_i(exc_eret_i),
    .stall_i(stall_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .except_type_o(except_type_o), .cur_inst_addr_o(cur_inst_addr_o),
    .in_delayslot_o(in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .exc_busy_o(exc_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference behaviour applied at one rising edge using the inputs present there.
  task automatic model_edge();
    logic [31:0] st, ca, ep, code;
    logic        ir;
    if (!rst) begin
      m_type = 0; m_cur = 0; m_pc = 0; m_ds = 0; m_flush = 0;
      idle_from = cyc + 1;
    end else begin
      m_type = 0; m_flush = 0; m_pc = 0;
      if (cyc >= idle_from && inst_valid_i && !stall_i) begin
        st = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_wdata_i : cp0_status_i;
        ep = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_wdata_i : cp0_epc_i;
        ca = cp0_cause_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
          ca[9:8] = wb_cp0_wdata_i[9:8];
          ca[23:22] = wb_cp0_wdata_i[23:22];
        end
        ir = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0);
        if (ir)                 code = 32'h1;
        else if (exc_invalid_i) code = 32'ha;
        else if (exc_syscall_i) code = 32'h8;
        else if (exc_trap_i)    code = 32'hd;
        else if (exc_ovf_i)     code = 32'hc;
        else if (exc_eret_i)    code = 32'he;
        else                    code = 32'h0;
        if (code != 0) begin
          m_type = code; m_flush = 1; m_cur = inst_addr_i; m_ds = in_delayslot_i;
          m_pc = (code == 32'he) ? ep : HANDLER;
          idle_from = cyc + 2 + BLANK;
        end
      end
    end
    m_busy = (cyc + 1 < idle_from);
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("except_type", except_type_o, m_type);
    check("flush", {31'b0, flush_o}, {31'b0, m_flush});
    check("new_pc", new_pc_o, m_pc);
    check("cur_inst_addr", cur_inst_addr_o, m_cur);
    check("in_delayslot", {31'b0, in_delayslot_o}, {31'b0, m_ds});
    check("exc_busy", {31'b0, exc_busy_o}, {31'b0, m_busy});
  endtask

  task automatic clr_in();
    inst_valid_i = 0; inst_addr_i = 0; in_delayslot_i = 0; stall_i = 0;
    exc_syscall_i = 0; exc_invalid_i = 0; exc_trap_i = 0; exc_ovf_i = 0; exc_eret_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
  endtask

  task automatic idle_steps(input int n);
    clr_in();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clr_in();
    rst = 0;
    step(); step();
    check("reset_type", except_type_o, 32'h0);
    check("reset_busy", {31'b0, exc_busy_o}, 32'h0);
    rst = 1;
    step();

    // syscall: code 0x8, redirect to handler, busy for 1+BLANK cycles
    inst_valid_i = 1; inst_addr_i = 32'h100; exc_syscall_i = 1;
    step();
    check("sys_type", except_type_o, 32'h8);
    check("sys_pc", new_pc_o, 32'h20);
    check("sys_addr", cur_inst_addr_o, 32'h100);
    idle_steps(4);

    // priority: interrupt wins, then invalid without interrupt
    inst_valid_i = 1; inst_addr_i = 32'h140; exc_invalid_i = 1; exc_syscall_i = 1;
    exc_ovf_i = 1; cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    step();
    check("prio_int", except_type_o, 32'h1);
    idle_steps(4);
    inst_valid_i = 1; inst_addr_i = 32'h144; exc_invalid_i = 1; exc_syscall_i = 1;
    exc_ovf_i = 1; cp0_cause_i = 32'h400; in_delayslot_i = 1;
    step();
    check("prio_inv", except_type_o, 32'ha);
    idle_steps(4);

    // eret picks forwarded EPC
    inst_valid_i = 1; inst_addr_i = 32'h180; exc_eret_i = 1; cp0_epc_i = 32'h200;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 14; wb_cp0_wdata_i = 32'h300;
    step();
    check("eret_pc", new_pc_o, 32'h300);
    idle_steps(4);

    // forwarded EXL masks pending interrupt
    inst_valid_i = 1; cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 12; wb_cp0_wdata_i = 32'h403;
    step();
    check("exl_mask", {31'b0, flush_o}, 32'h0);
    idle_steps(1);

    // stall gates detection; trap held through blanking fires once back in IDLE
    inst_valid_i = 1; exc_trap_i = 1; stall_i = 1;
    step(); step();
    stall_i = 0; exc_trap_i = 0; exc_ovf_i = 1; inst_addr_i = 32'h1c0;
    step();
    exc_ovf_i = 0; exc_trap_i = 1;
    for (int i = 0; i < 4; i++) step();
    check("blank_second", except_type_o, 32'hd);
    idle_steps(4);

    // reset during the flush cycle
    inst_valid_i = 1; inst_addr_i = 32'h200; exc_syscall_i = 1;
    step();
    clr_in(); rst = 0;
    step();
    check("rst_flush_busy", {31'b0, exc_busy_o}, 32'h0);
    rst = 1; inst_valid_i = 1; exc_ovf_i = 1; inst_addr_i = 32'h204;
    step();
    check("after_rst", except_type_o, 32'hc);
    idle_steps(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) >= 2);
      inst_valid_i = ($urandom_range(0, 9) < 8);
      inst_addr_i = {$urandom} & 32'hffff_fffc;
      in_delayslot_i = $urandom_range(0, 1);
      stall_i = ($urandom_range(0, 9) < 2);
      exc_syscall_i = ($urandom_range(0, 9) < 2);
      exc_invalid_i = ($urandom_range(0, 9) < 1);
      exc_trap_i = ($urandom_range(0, 9) < 2);
      exc_ovf_i = ($urandom_range(0, 9) < 2);
      exc_eret_i = ($urandom_range(0, 9) < 2);
      cp0_status_i = $urandom;
      cp0_status_i[0] = ($urandom_range(0, 3) != 0);
      cp0_status_i[1] = ($urandom_range(0, 3) == 0);
      cp0_cause_i = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hffff_00ff);
      cp0_epc_i = $urandom;
      wb_cp0_we_i = ($urandom_range(0, 3) == 0);
      wb_cp0_waddr_i = 5'($urandom_range(11, 15));
      wb_cp0_wdata_i = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception controller for the pipeline's memory stage; it drives coprocessor 0's exception inputs. It takes per-instruction exception flags, the live CP0 status/cause/EPC values, and any CP0 write still in flight from write-back. From these it picks one exception per instruction and issues a single-cycle exception code toward CP0, along with a pipeline flush and a redirect PC. After each exception it blanks further detection while the pipeline refills.

## Interface
Parameters:
- HANDLER_ADDR, 32'h00000020, redirect target for every exception except eret
- BLANK_CYCLES, 2, cycles after a flush during which detection is suppressed (0 allowed)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (`rst == 0` resets on the clock edge)
- inst_valid_i  in  1  memory-stage slot holds a real instruction
- inst_addr_i  in  32  address of that instruction
- in_delayslot_i  in  1  instruction sits in a branch delay slot
- exc_syscall_i, exc_invalid_i, exc_trap_i, exc_ovf_i, exc_eret_i  in  1 each  per-instruction exception flags
- stall_i  in  1  memory stage stalled this cycle
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  CP0 write pending in write-back
- wb_cp0_waddr_i  in  5  its register number
- wb_cp0_wdata_i  in  32  its data
- except_type_o  out  32  exception code to CP0, nonzero for exactly one cycle per exception
- cur_inst_addr_o  out  32  faulting instruction address to CP0
- in_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  pipeline flush pulse
- new_pc_o  out  32  redirect PC, valid while flush_o is high
- exc_busy_o  out  1  high in FLUSH and HOLD

## Operation
Forwarding produces the effective CP0 values used for detection:
- **Status:** eff_status = wb_cp0_wdata_i if wb_cp0_we_i and waddr==12; otherwise cp0_status_i.
- **EPC:** eff_epc = wb_cp0_wdata_i if the write targets register 14; otherwise cp0_epc_i.
- **Cause:** eff_cause = cp0_cause_i, except that a write to register 13 replaces bits 9:8, 22 and 23 with the corresponding wdata bits.

Interrupt condition:
- int_req = eff_status[0] & ~eff_status[1] & |(eff_cause[15:8] & eff_status[15:8]).

Detection is enabled only when state==IDLE, inst_valid_i=1 and stall_i=0. The code is chosen by fixed priority, highest first:
- interrupt → 32'h1
- invalid → 32'ha
- syscall → 32'h8
- trap → 32'hd
- overflow → 32'hc
- eret → 32'he
- none → 0; state stays IDLE.

State machine:
- **IDLE:** on a detected code, register the outputs below and go to FLUSH.
  - except_type_o = code
  - cur_inst_addr_o = inst_addr_i
  - in_delayslot_o = in_delayslot_i
  - flush_o = 1
  - new_pc_o = eff_epc for eret, else HANDLER_ADDR
- **FLUSH (one cycle):** outputs above are visible. Next edge clears except_type_o, flush_o and new_pc_o to 0. Go to HOLD with blank counter = BLANK_CYCLES-1; go straight to IDLE if BLANK_CYCLES==0.
- **HOLD:** counter decrements each cycle and flags are ignored. At 0, go to IDLE.

Other rules:
- cur_inst_addr_o and in_delayslot_o hold their last values until the next exception.
- stall_i does not freeze FLUSH or HOLD; only detection is gated by it.
- Delay-slot EPC correction (−4) is done by CP0. This block passes the raw address through.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0. Reset applied in FLUSH or HOLD aborts immediately. except_type_o and flush_o are 0 at the next edge; no partial pulse repeats.
- **Latency:** inputs in cycle N produce registered outputs valid during cycle N+1. Detection next possible in cycle N+2+BLANK_CYCLES.
- except_type_o and flush_o are always coincident and exactly one cycle wide.
- A wb CP0 write and a detection in the same cycle: the forwarded value wins (e.g. a write setting EXL masks the interrupt).
- Flags arriving during FLUSH or HOLD are dropped, not queued.
- The blank counter is $clog2(BLANK_CYCLES+1) bits wide (minimum 1) and does not wrap.

## Test plan
- **Syscall:** status=0, inst_addr=0x100, exc_syscall=1 for one cycle → next cycle except_type_o=0x8, cur_inst_addr_o=0x100, flush_o=1, new_pc_o=0x20. Cycle after that, all three pulse outputs are 0; exc_busy_o stays high 3 cycles in total.
- **Priority:** exc_invalid, exc_syscall and exc_ovf together, with int_req=1 (status=0x0000_0401, cause=0x0000_0400) → except_type_o=0x1. Same test with status=0 → 0xa.
- **Eret with forwarding:** cp0_epc_i=0x200, wb write to reg 14 with 0x300, exc_eret=1 → except_type_o=0xe, new_pc_o=0x300.
- **Forwarded EXL masks interrupt:** wb writes status=0x0000_0403 with interrupt pending → no exception, flush_o stays 0.
- **Stall and blanking:** stall_i=1 with exc_trap → nothing issued. After an overflow exception, exc_trap held high through the 2 HOLD cycles → second exception (0xd) issued only once back in IDLE.
- **Reset in FLUSH:** rst=0 during the flush cycle → next edge all outputs 0, state IDLE; a flag after reset release is handled normally.
